msg_scheduler: RTL and testbench

Expands each 512-bit message block into the 64-word SHA-256 message schedule W[0..63] (FIPS 180-4 §6.2.2 step 1). It sits directly downstream of the padder. It consumes the padder's 16 words per block, one per enabled cycle, and feeds one W_t per enabled cycle to the compression round logic. A 16-entry shift register holds the sliding window, so no 64-word storage is needed.

---
 rtl/msg_scheduler.sv | 104 ++++++++++
 tb/tb_msg_scheduler.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/msg_scheduler.sv
// SHA-256 message schedule expander: 16 loaded words, then 48 expanded words, through a 16-word sliding window.
// Optional build macro MSG_SCHED_PRECOMP_EN pre-adds the sigma0/W[t-7]/W[t-16] terms one cycle early.
module msg_scheduler (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        start,
  input  logic [31:0] w_in,
  output logic [31:0] w_out,
  output logic [5:0]  w_idx,
  output logic        w_valid,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {IDLE, LOAD, EXPAND, DONE} state_t;

  state_t      state, state_next;
  logic [5:0]  t;
  logic [31:0] s [16];
  logic [31:0] n;
  logic        load_cyc;
  logic        exp_cyc;
`ifdef MSG_SCHED_PRECOMP_EN
  logic [31:0] p;
`endif

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    load_cyc   = 1'b0;
    exp_cyc    = 1'b0;
    case (state)
      IDLE:   if (en && start) state_next = LOAD;
      LOAD:   if (en) begin
                load_cyc = 1'b1;
                if (t == 6'd15) state_next = EXPAND;
              end
      EXPAND: if (en) begin
                exp_cyc = 1'b1;
                if (t == 6'd63) state_next = DONE;
              end
      DONE:   if (en) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state == LOAD) || (state == EXPAND);

  // Next schedule word; s[14] = W[t-2], s[9] = W[t-7], s[1] = W[t-15], s[0] = W[t-16]
  always_comb begin
`ifdef MSG_SCHED_PRECOMP_EN
    n = sig1(s[14]) + p;
`else
    n = sig1(s[14]) + s[9] + sig0(s[1]) + s[0];
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      t       <= '0;
      w_out   <= '0;
      w_idx   <= '0;
      w_valid <= 1'b0;
      done    <= 1'b0;
      for (int i = 0; i < 16; i++) s[i] <= '0;
    end else begin
      w_valid <= load_cyc || exp_cyc;
      done    <= en && (state == DONE);
      if (state == IDLE && en && start) t <= '0;
      if (load_cyc || exp_cyc) begin
        for (int i = 0; i < 15; i++) s[i] <= s[i+1];
        s[15] <= load_cyc ? w_in : n;
        w_out <= load_cyc ? w_in : n;
        w_idx <= t;
        t     <= t + 6'd1;
      end
    end
  end

`ifdef MSG_SCHED_PRECOMP_EN
  // Terms of next cycle's sum, seen through the window as it will be after this shift
  always_ff @(posedge clk) begin
    if (reset) begin
      p <= '0;
    end else if ((load_cyc && t >= 6'd14) || exp_cyc) begin
      p <= s[1] + s[10] + sig0(s[2]);
    end
  end
`endif

endmodule

// File: tb/tb_msg_scheduler.sv
// Self-checking bench for msg_scheduler: table of block tests against a full 64-word schedule model,
// plus hand-written reset-abort and held-start sequences.
module tb_msg_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic        start;
  logic [31:0] w_in;
  logic [31:0] w_out;
  logic [5:0]  w_idx;
  logic        w_valid;
  logic        busy;
  logic        done;

  msg_scheduler dut (
    .clk     (clk),
    .reset   (reset),
    .en      (en),
    .start   (start),
    .w_in    (w_in),
    .w_out   (w_out),
    .w_idx   (w_idx),
    .w_valid (w_valid),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  logic [31:0] blk   [16];
  logic [31:0] exp_w [64];
  logic [31:0] cap   [256];
  int cap_n    = 0;
  int idx_bad  = 0;
  int vld_bad  = 0;
  int done_cnt = 0;
  int done_edge = 0;
  int edge_n   = 0;
  int start_edge = 0;
  logic en_q = 1'b0;

  typedef struct {
    string name;
    int    pattern;
    bit    stall;
    bit    chk_lat;
  } blk_vec_t;

  typedef struct {
    logic [5:0]  idx;
    logic [31:0] w;
  } abc_vec_t;

  blk_vec_t vecs [4];
  abc_vec_t abc_tab [5];

  function automatic logic [31:0] ror(input logic [31:0] x, input int k);
    return (x >> k) | (x << (32 - k));
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
  endfunction

  task automatic compute_model();
    for (int i = 0; i < 64; i++) begin
      if (i < 16) exp_w[i] = blk[i];
      else exp_w[i] = ssig1(exp_w[i-2]) + exp_w[i-7] + ssig0(exp_w[i-15]) + exp_w[i-16];
    end
  endtask

  task automatic fill_block(input int pattern);
    for (int i = 0; i < 16; i++) begin
      case (pattern)
        0:       blk[i] = (i == 0) ? 32'h61626380 : ((i == 15) ? 32'h00000018 : 32'h0);
        1:       blk[i] = $urandom;
        default: blk[i] = 32'hFFFFFFFF;
      endcase
    end
    compute_model();
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    cap_n = 0; idx_bad = 0; vld_bad = 0; done_cnt = 0; done_edge = 0;
  endtask

  always @(posedge clk) begin
    edge_n <= edge_n + 1;
    en_q   <= en;
  end

  always @(negedge clk) begin
    if (w_valid === 1'b1) begin
      if (w_idx !== 6'(cap_n % 64)) idx_bad++;
      if (cap_n < 256) cap[cap_n] = w_out;
      cap_n++;
      if (!en_q) vld_bad++;
    end
    if (done === 1'b1) begin
      done_cnt++;
      done_edge = edge_n;
      if (!en_q) vld_bad++;
    end
  end

  task automatic run_block(input bit stall);
    int ptr;
    int guard;
    clear_mon();
    en = 1'b1; start = 1'b1;
    step();
    start_edge = edge_n;
    start = 1'b0;
    ptr = 0; guard = 0;
    while (ptr < 65 && guard < 2000) begin
      en   = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      w_in = (ptr < 16) ? blk[ptr] : 32'h0;
      step();
      if (en) ptr++;
      guard++;
    end
    en = 1'b1; w_in = '0;
    step();
    step();
    chk("block_cycle_budget", 64'(ptr), 64'd65);
  endtask

  task automatic check_words(input string name, input int base);
    for (int i = 0; i < 64; i++)
      chk($sformatf("%s_W%0d", name, i), cap[base + i], exp_w[i]);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{"abc",       0, 1'b0, 1'b1};
    vecs[1] = '{"random",    1, 1'b0, 1'b1};
    vecs[2] = '{"all_ones",  2, 1'b0, 1'b1};
    vecs[3] = '{"abc_stall", 0, 1'b1, 1'b0};
    abc_tab[0] = '{6'd0,  32'h61626380};
    abc_tab[1] = '{6'd15, 32'h00000018};
    abc_tab[2] = '{6'd16, 32'h61626380};
    abc_tab[3] = '{6'd17, 32'h000F0000};
    abc_tab[4] = '{6'd18, 32'h7DA86405};

    reset = 1'b1; en = 1'b0; start = 1'b0; w_in = '0;
    step(); step();
    chk("reset_w_out",   64'(w_out),   64'd0);
    chk("reset_w_idx",   64'(w_idx),   64'd0);
    chk("reset_w_valid", 64'(w_valid), 64'd0);
    chk("reset_busy",    64'(busy),    64'd0);
    chk("reset_done",    64'(done),    64'd0);
    reset = 1'b0;
    step();

    // Start without en must be ignored
    start = 1'b1; en = 1'b0;
    step(); step();
    chk("start_no_en_busy", 64'(busy), 64'd0);
    start = 1'b0; en = 1'b1;
    step();

    for (int v = 0; v < 4; v++) begin
      fill_block(vecs[v].pattern);
      run_block(vecs[v].stall);
      chk({vecs[v].name, "_valid_count"}, 64'(cap_n), 64'd64);
      chk({vecs[v].name, "_idx_seq_err"}, 64'(idx_bad), 64'd0);
      chk({vecs[v].name, "_valid_without_en"}, 64'(vld_bad), 64'd0);
      chk({vecs[v].name, "_done_count"}, 64'(done_cnt), 64'd1);
      if (vecs[v].chk_lat)
        chk({vecs[v].name, "_done_latency"}, 64'(done_edge - start_edge), 64'd65);
      if (vecs[v].pattern == 0)
        for (int k = 0; k < 5; k++)
          chk($sformatf("%s_hand_W%0d", vecs[v].name, abc_tab[k].idx),
              cap[abc_tab[k].idx], abc_tab[k].w);
      check_words(vecs[v].name, 0);
    end

    // Reset in the middle of a block, with t at 30
    fill_block(0);
    clear_mon();
    en = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    for (int ptr = 0; ptr < 30; ptr++) begin
      w_in = (ptr < 16) ? blk[ptr] : 32'h0;
      step();
    end
    chk("pre_abort_busy", 64'(busy), 64'd1);
    reset = 1'b1;
    step();
    chk("abort_w_out",   64'(w_out),   64'd0);
    chk("abort_w_idx",   64'(w_idx),   64'd0);
    chk("abort_w_valid", 64'(w_valid), 64'd0);
    chk("abort_busy",    64'(busy),    64'd0);
    chk("abort_done",    64'(done),    64'd0);
    reset = 1'b0;
    for (int i = 0; i < 70; i++) step();
    chk("abort_no_done", 64'(done_cnt), 64'd0);
    chk("abort_idle_busy", 64'(busy), 64'd0);
    run_block(1'b0);
    chk("after_abort_valid_count", 64'(cap_n), 64'd64);
    chk("after_abort_W0", cap[0], 32'h61626380);
    check_words("after_abort", 0);

    // start held high: three back-to-back blocks
    fill_block(1);
    clear_mon();
    en = 1'b1; start = 1'b1;
    for (int b = 0; b < 3; b++) begin
      for (int c = 0; c < 66; c++) begin
        w_in = (c >= 1 && c <= 16) ? blk[c-1] : 32'h0;
        step();
      end
    end
    start = 1'b0; w_in = '0;
    step(); step();
    chk("held_valid_count", 64'(cap_n), 64'd192);
    chk("held_idx_seq_err", 64'(idx_bad), 64'd0);
    chk("held_done_count", 64'(done_cnt), 64'd3);
    chk("held_idle_busy", 64'(busy), 64'd0);
    for (int b = 0; b < 3; b++) check_words($sformatf("held_blk%0d", b), b * 64);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
